// File: rtl/ll_fifo_pop_arbiter.sv
// Pops entries from NUM_FIFOS upstream fifos into a 2-entry output queue.
// Grant is round-robin by default; define LL_POP_ARB_STRICT_PRIO_EN for lowest-index priority.
module ll_fifo_pop_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_pop,
    output logic [SEL_WIDTH-1:0] fifo_pop_sel,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_sel
);

    // Handshake: an entry moves downstream on any rising edge where out_valid
    // and out_ready are both 1; out_valid never waits on out_ready.

    logic [NUM_FIFOS-1:0] req;
    logic                 any_req;
    logic [SEL_WIDTH-1:0] grant;
    logic [1:0]           count;
    logic                 transfer;
    logic                 wr_slot;
    logic [WIDTH-1:0]     q_data [2];
    logic [SEL_WIDTH-1:0] q_sel  [2];

    assign req     = ~fifo_empty;
    assign any_req = |req;

`ifdef LL_POP_ARB_STRICT_PRIO_EN
    always_comb begin
        grant = '0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (req[i]) grant = SEL_WIDTH'(i);
        end
    end
`else
    logic [SEL_WIDTH-1:0] last_grant;
    logic [SEL_WIDTH-1:0] grant_lo;
    logic [SEL_WIDTH-1:0] grant_hi;
    logic                 hi_found;

    // Requests above the last grant win; otherwise wrap to the lowest request.
    always_comb begin
        grant_lo = '0;
        grant_hi = '0;
        hi_found = 1'b0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (req[i]) grant_lo = SEL_WIDTH'(i);
            if (req[i] && (i > int'(last_grant))) begin
                grant_hi = SEL_WIDTH'(i);
                hi_found = 1'b1;
            end
        end
        grant = hi_found ? grant_hi : grant_lo;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= SEL_WIDTH'(NUM_FIFOS - 1);
        end else if (fifo_pop) begin
            last_grant <= grant;
        end
    end
`endif

    assign fifo_pop     = rst && en && (count != 2'd2) && any_req;
    assign fifo_pop_sel = fifo_pop ? grant : '0;

    assign out_valid = (count != 2'd0);
    assign transfer  = out_valid && out_ready;
    assign out_data  = q_data[0];
    assign out_sel   = q_sel[0];

    // New entry lands behind whatever survives this edge's retirement.
    assign wr_slot = (count == 2'd1) && !transfer;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, fifo_pop} - {1'b0, transfer};
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) begin
            q_data[0] <= q_data[1];
            q_sel[0]  <= q_sel[1];
        end
        if (fifo_pop) begin
            if (wr_slot) begin
                q_data[1] <= fifo_data;
                q_sel[1]  <= grant;
            end else begin
                q_data[0] <= fifo_data;
                q_sel[0]  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_ll_fifo_pop_arbiter.sv
// Bench for ll_fifo_pop_arbiter: directed scenarios then random traffic against a queue model.
module tb_ll_fifo_pop_arbiter;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          fifo_pop;
    logic [SW-1:0] fifo_pop_sel;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_sel;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: entries in pop order as {sel, data}; last granted index.
    logic [SW+W-1:0] exp_q[$];
    int              model_last;

    ll_fifo_pop_arbiter #(.WIDTH(W), .NUM_FIFOS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_pop     (fifo_pop),
        .fifo_pop_sel (fifo_pop_sel),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sel      (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int model_grant(input logic [N-1:0] emp);
        int g;
        g = -1;
`ifdef LL_POP_ARB_STRICT_PRIO_EN
        for (int i = 0; i < N; i++)
            if (g < 0 && !emp[i]) g = i;
`else
        for (int k = 1; k <= N; k++)
            if (g < 0 && !emp[(model_last + k) % N]) g = (model_last + k) % N;
`endif
        return g;
    endfunction

    // One clock cycle: drive at negedge, check outputs, advance model at posedge.
    task automatic step(input logic r, input logic e, input logic [N-1:0] emp, input logic rdy);
        int            g;
        logic          exp_pop;
        logic          exp_valid;
        logic [W-1:0]  d;
        @(negedge clk);
        rst        = r;
        en         = e;
        fifo_empty = emp;
        out_ready  = rdy;
        d          = W'($urandom);
        fifo_data  = d;
        #1;
        g         = model_grant(emp);
        exp_pop   = r && e && (exp_q.size() < 2) && (g >= 0);
        exp_valid = (exp_q.size() != 0);
        check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        check("fifo_pop_sel", 32'(fifo_pop_sel), exp_pop ? 32'(g) : 32'd0);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
            check("out_sel", 32'(out_sel), 32'(exp_q[0][SW+W-1:W]));
        end
        if (fifo_pop && !emp[fifo_pop_sel]) ; else if (fifo_pop)
            check("pop_of_empty", 32'(fifo_pop_sel), 32'hFFFF_FFFF);
        @(posedge clk);
        if (!r) begin
            exp_q.delete();
            model_last = N - 1;
        end else begin
            if (exp_valid && rdy) void'(exp_q.pop_front());
            if (exp_pop) begin
                exp_q.push_back({SW'(g), d});
`ifndef LL_POP_ARB_STRICT_PRIO_EN
                model_last = g;
`endif
            end
        end
    endtask

    initial begin
        model_last = N - 1;
        rst = 1'b0; en = 1'b0; fifo_empty = '1; fifo_data = '0; out_ready = 1'b0;

        repeat (3) step(1'b0, 1'b1, 2'b00, 1'b1);

        // Both non-empty, free-flowing: alternating grants.
        repeat (10) step(1'b1, 1'b1, 2'b00, 1'b1);
        // Stall: fill to two, hold, then drain in order.
        repeat (6) step(1'b1, 1'b1, 2'b00, 1'b0);
        repeat (4) step(1'b1, 1'b1, 2'b00, 1'b1);
        // Only fifo 1 has data.
        repeat (4) step(1'b1, 1'b1, 2'b01, 1'b1);
        // Only fifo 0, then nothing.
        repeat (3) step(1'b1, 1'b1, 2'b10, 1'b1);
        repeat (3) step(1'b1, 1'b1, 2'b11, 1'b1);
        // Reset with a full queue; first pop afterwards picks fifo 0.
        repeat (3) step(1'b1, 1'b1, 2'b00, 1'b0);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        repeat (3) step(1'b1, 1'b1, 2'b00, 1'b1);
        // Full queue, then en low while draining.
        repeat (3) step(1'b1, 1'b1, 2'b00, 1'b0);
        repeat (4) step(1'b1, 1'b0, 2'b00, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) != 0,
                 N'($urandom),
                 $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ll_fifo_pop_arbiter.md
LL_FIFO_POP_ARBITER -- requirements
Module: ll_fifo_pop_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, as the data width; it SHALL match the width of the upstream shared-memory fifo.
REQ-002 The block SHALL have parameter NUM_FIFOS, default 2, as the number of upstream fifos arbitrated.
REQ-003 The block SHALL have parameter SEL_WIDTH, default $clog2(NUM_FIFOS), as the fifo index width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 en  input  1  arbitration enable; 0 blocks new pops only.
REQ-007 fifo_empty  input  NUM_FIFOS  bit i = 1 when upstream fifo i is empty.
REQ-008 fifo_data  input  WIDTH  upstream read data, valid combinationally in the cycle fifo_pop=1.
REQ-009 fifo_pop  output  1  pop strobe to the upstream fifo.
REQ-010 fifo_pop_sel  output  SEL_WIDTH  index of the fifo popped.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_valid  output  1  out_data/out_sel hold a valid entry.
REQ-013 out_data  output  WIDTH  head-entry data.
REQ-014 out_sel  output  SEL_WIDTH  source fifo index of the head entry.

Function
REQ-015 The block SHALL contain a 2-entry output queue (data+sel per entry) with occupancy count 0..2.
REQ-016 fifo_pop SHALL be 1 only when en=1, count<2 and fifo_empty is not all-ones; it SHALL NOT depend combinationally on out_ready.
REQ-017 fifo_pop SHALL never be asserted for a fifo whose fifo_empty bit is 1; fifo_pop_sel SHALL be the granted index, and 0 when fifo_pop=0.
REQ-018 On fifo_pop=1, {fifo_data, fifo_pop_sel} SHALL be written into the queue at the clock edge; out_valid SHALL be 1 in the next cycle (latency 1).
REQ-019 A transfer SHALL occur when out_valid=1 and out_ready=1; the head SHALL retire on that edge.
REQ-020 When a pop and a transfer occur together, count SHALL remain unchanged and ordering SHALL be preserved; with count=1 and out_ready held high, one entry per cycle SHALL be sustained.
REQ-021 out_valid SHALL equal (count!=0); out_data/out_sel SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Round-robin grant: a last-grant register SHALL hold the most recently popped index; the grant SHALL be the first non-empty fifo searching upward from last+1, wrapping from NUM_FIFOS-1 to 0.
REQ-023 The last-grant register SHALL update only on cycles with fifo_pop=1.
REQ-024 When only the last-granted fifo is non-empty, it SHALL be granted again.
REQ-025 With count=2, no pop SHALL occur regardless of out_ready, and fifo_empty SHALL be ignored.
REQ-026 Deasserting en SHALL not affect draining of queued entries.

Reset
REQ-027 With rst=0 at a clock edge: count=0, out_valid=0, last-grant=NUM_FIFOS-1 (so fifo 0 is searched first), fifo_pop=0 in the same cycle.
REQ-028 Reset asserted mid-operation SHALL discard queued entries; out_data/out_sel contents are don't-care while out_valid=0.

Configuration
REQ-029 Macro LL_POP_ARB_STRICT_PRIO_EN: when defined, the grant SHALL be the lowest-index non-empty fifo and the last-grant register SHALL be omitted; when undefined, round-robin per REQ-022..REQ-024 SHALL apply.

Verification
REQ-030 Reset, then fifo_empty=2'b00, en=1, out_ready=1, round-robin -> pops alternate sel 0,1,0,1; out_sel follows one cycle later; one transfer per cycle.
REQ-031 out_ready=0, both fifos non-empty -> exactly 2 pops, then fifo_pop=0 while stalled; out_data held; on out_ready=1 entries emerge in pop order.
REQ-032 fifo_empty=2'b01 (fifo 1 only), 4 cycles -> fifo_pop_sel=1 every cycle; no pop of fifo 0.
REQ-033 Both fifos non-empty, LL_POP_ARB_STRICT_PRIO_EN defined -> fifo_pop_sel=0 every cycle until fifo_empty[0]=1.
REQ-034 rst=0 asserted with count=2 -> next cycle out_valid=0, count=0; first pop after release selects fifo 0.
REQ-035 en=0 with count=2, out_ready=1 -> two transfers, then out_valid=0 and fifo_pop stays 0.
